// File: rtl/cdc_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdc_arb_pkg
// Shared types and constants for the mailbox write arbiter.
//   data_t      : one 16-bit buffer word
//   arb_state_t : arbiter FSM states (IDLE, HOLDOFF)
//   GAP_W       : width of the post-write spacing counter
// ----------------------------------------------------------------------------
package cdc_arb_pkg;

    localparam int DATA_W = 16;
    localparam int GAP_W  = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cdc_write_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Picks the first set bit of `valid`
// searching upward from `ptr`, wrapping at NUM_REQ (not a power-of-two wrap).
// Ports:
//   valid     in  [NUM_REQ]  request vector
//   ptr       in  [PTR_W]    search start index, always < NUM_REQ
//   grant     out [NUM_REQ]  one-hot grant (all zero when nothing valid)
//   grant_idx out [PTR_W]    index of the granted requester
//   any       out            at least one request is valid
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_ofs;
    logic [PTR_W:0]       w_sum;

    // Rotate right by ptr so bit k of w_rot is requester (ptr+k) mod NUM_REQ.
    assign w_dbl = {valid, valid};
    assign w_rot = NUM_REQ'(w_dbl >> ptr);

    // Lowest set bit of the rotated vector is the nearest requester above ptr.
    always_comb begin
        w_ofs = '0;
        any   = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_ofs = PTR_W'(j);
                any   = 1'b1;
            end
        end
    end

    // Undo the rotation; both operands are < NUM_REQ so one subtract suffices.
    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_ofs};
        if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (PTR_W + 1)'(NUM_REQ);
        end
    end

    assign grant_idx = w_sum[PTR_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = any && (grant_idx == PTR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/cdc_write_arbiter.sv
// ----------------------------------------------------------------------------
// cdc_write_arbiter
// Round-robin arbiter sharing the single 16-bit write port of the cross-clock
// mailbox buffer between NUM_REQ requesters. After each buffer write it forces
// MIN_GAP idle cycles so the read domain can sample the word before it is
// overwritten.
//
// Optional feature macro: CDC_WRITE_ARBITER_STATS_EN
//   Adds a saturating CNT_W-bit grant counter per requester and the
//   stat_sel / stat_count readout ports.
//
// Ports:
//   clk         in   write-domain clock (same net as buffer write_clk)
//   reset       in   synchronous, active-high
//   req_valid   in   [NUM_REQ]     per-requester valid
//   req_data    in   [NUM_REQ*16]  requester i in bits [16i+15:16i]
//   req_ready   out  [NUM_REQ]     one-hot accept, combinational
//   write_data  out  [16]          registered buffer write word
//   write_en    out                registered single-cycle write strobe
//   last_grant  out  [clog2 N]     most recently accepted requester
//   busy        out                high while in HOLDOFF
//   stat_sel    in   [clog2 N]     (stats build) counter select
//   stat_count  out  [CNT_W]       (stats build) counter[stat_sel], 1 cycle later
// ----------------------------------------------------------------------------
module cdc_write_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MIN_GAP = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          write_data,
    output logic                       write_en,
    output logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic                       busy
`ifdef CDC_WRITE_ARBITER_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [CNT_W-1:0]           stat_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [GAP_W-1:0] GAP_INIT =
        (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

    // Reject configurations outside the supported range at elaboration.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || MIN_GAP < 0 || MIN_GAP > 255 || CNT_W < 1) begin : g_bad_cfg
            $error("cdc_write_arbiter: unsupported parameter combination");
        end
    endgenerate

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_next;
    data_t            r_write_data;
    logic             r_write_en;
    logic [PTR_W-1:0] r_last_grant;

    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_any;
    logic               w_xfer;
    data_t              w_req_word [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_word[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .valid     (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_idx),
        .any       (w_any)
    );

    // Next-state and handshake logic. Ready is offered only in IDLE, so any
    // valid request seen in IDLE is a transfer this cycle.
    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap_cnt;
        w_ptr_next   = r_ptr;
        req_ready    = '0;
        w_xfer       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = w_grant;
                if (w_any) begin
                    w_xfer     = 1'b1;
                    w_ptr_next = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                    if (MIN_GAP != 0) begin
                        w_state_next = HOLDOFF;
                        w_gap_next   = GAP_INIT;
                    end
                end
            end
            HOLDOFF: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_gap_next = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Reset drops any HOLDOFF and the write strobe that a transfer in the
    // reset cycle would otherwise produce.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_gap_cnt    <= '0;
            r_write_data <= '0;
            r_write_en   <= 1'b0;
            r_last_grant <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_gap_cnt  <= w_gap_next;
            r_write_en <= w_xfer;
            if (w_xfer) begin
                r_write_data <= w_req_word[w_idx];
                r_last_grant <= w_idx;
            end
        end
    end

    assign write_data = r_write_data;
    assign write_en   = r_write_en;
    assign last_grant = r_last_grant;
    assign busy       = (r_state == HOLDOFF);

`ifdef CDC_WRITE_ARBITER_STATS_EN
    logic [CNT_W-1:0]   r_grant_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] w_cnt_inc;
    logic [CNT_W-1:0]   r_stat_count;

    // Increment only the granted requester's counter, holding at all-ones.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_inc
            assign w_cnt_inc[gi] = w_xfer && (w_idx == PTR_W'(gi)) &&
                                   (r_grant_cnt[gi] != '1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
            r_stat_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_cnt_inc[i]) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + CNT_W'(1);
                end
            end
            // stat_sel codes beyond NUM_REQ-1 read as zero.
            if ({1'b0, stat_sel} < (PTR_W + 1)'(NUM_REQ)) begin
                r_stat_count <= r_grant_cnt[stat_sel];
            end else begin
                r_stat_count <= '0;
            end
        end
    end

    assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_cdc_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdc_write_arbiter
// Three arbiter instances: A (4 req, gap 4, 4-bit counters), B (4 req, gap 0),
// C (3 req, gap 0). Expected writes are queued when a grant is expected and
// popped when the instance raises write_en.
// ----------------------------------------------------------------------------
module tb_cdc_write_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ent(input int idx, input logic [15:0] d);
        return {8'h00, 8'(idx), d};
    endfunction

    // ---------------- DUT A ----------------
    logic [3:0]  a_valid, a_ready;
    logic [63:0] a_data;
    logic [15:0] a_wd;
    logic        a_we, a_busy;
    logic [1:0]  a_lg;
    // ---------------- DUT B ----------------
    logic [3:0]  b_valid, b_ready;
    logic [63:0] b_data;
    logic [15:0] b_wd;
    logic        b_we, b_busy;
    logic [1:0]  b_lg;
    // ---------------- DUT C ----------------
    logic [2:0]  c_valid, c_ready;
    logic [47:0] c_data;
    logic [15:0] c_wd;
    logic        c_we, c_busy;
    logic [1:0]  c_lg;
`ifdef CDC_WRITE_ARBITER_STATS_EN
    logic [1:0]  a_sel, b_sel, c_sel;
    logic [3:0]  a_cnt;
    logic [15:0] b_cnt, c_cnt;
`endif

    cdc_write_arbiter #(.NUM_REQ(4), .MIN_GAP(4), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(a_valid), .req_data(a_data),
        .req_ready(a_ready), .write_data(a_wd), .write_en(a_we),
        .last_grant(a_lg), .busy(a_busy)
`ifdef CDC_WRITE_ARBITER_STATS_EN
        , .stat_sel(a_sel), .stat_count(a_cnt)
`endif
    );

    cdc_write_arbiter #(.NUM_REQ(4), .MIN_GAP(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .write_data(b_wd), .write_en(b_we),
        .last_grant(b_lg), .busy(b_busy)
`ifdef CDC_WRITE_ARBITER_STATS_EN
        , .stat_sel(b_sel), .stat_count(b_cnt)
`endif
    );

    cdc_write_arbiter #(.NUM_REQ(3), .MIN_GAP(0), .CNT_W(16)) u_dut_c (
        .clk(clk), .reset(reset), .req_valid(c_valid), .req_data(c_data),
        .req_ready(c_ready), .write_data(c_wd), .write_en(c_we),
        .last_grant(c_lg), .busy(c_busy)
`ifdef CDC_WRITE_ARBITER_STATS_EN
        , .stat_sel(c_sel), .stat_count(c_cnt)
`endif
    );

    // ---------------- scoreboards ----------------
    logic [31:0] qa[$], qb[$], qc[$];
    logic [31:0] ea, eb, ec;
    logic        mon_on = 1'b0;
    int          a_last_we = -100;

    always @(negedge clk) begin
        if (mon_on && a_we) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_write", 32'(a_lg), 32'hFF);
            end else begin
                ea = qa.pop_front();
                $display("A write: data=0x%04h grant=%0d", a_wd, a_lg);
                chk("a_write_data", 32'(a_wd), 32'(ea[15:0]));
                chk("a_last_grant", 32'(a_lg), 32'(ea[23:16]));
            end
            chk("a_write_spacing", 32'((cyc - a_last_we) >= 5), 32'd1);
            a_last_we = cyc;
        end
        if (reset) a_last_we = -100;
    end

    always @(negedge clk) begin
        if (mon_on && b_we) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_write", 32'(b_lg), 32'hFF);
            end else begin
                eb = qb.pop_front();
                $display("B write: data=0x%04h grant=%0d", b_wd, b_lg);
                chk("b_write_data", 32'(b_wd), 32'(eb[15:0]));
                chk("b_last_grant", 32'(b_lg), 32'(eb[23:16]));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on && c_we) begin
            if (qc.size() == 0) begin
                chk("c_unexpected_write", 32'(c_lg), 32'hFF);
            end else begin
                ec = qc.pop_front();
                $display("C write: data=0x%04h grant=%0d", c_wd, c_lg);
                chk("c_write_data", 32'(c_wd), 32'(ec[15:0]));
                chk("c_last_grant", 32'(c_lg), 32'(ec[23:16]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 10000", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset   = 1'b1;
        a_valid = '0; a_data = '0;
        b_valid = '0; b_data = '0;
        c_valid = '0; c_data = '0;
`ifdef CDC_WRITE_ARBITER_STATS_EN
        a_sel = '0; b_sel = '0; c_sel = '0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_on = 1'b1;
        #1;

        // Reset values
        chk("rst_a_we",    32'(a_we),   0);
        chk("rst_a_wdata", 32'(a_wd),   0);
        chk("rst_a_lg",    32'(a_lg),   0);
        chk("rst_a_busy",  32'(a_busy), 0);
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_b_we",    32'(b_we),   0);
        chk("rst_b_busy",  32'(b_busy), 0);
        chk("rst_c_we",    32'(c_we),   0);
        chk("rst_c_lg",    32'(c_lg),   0);

        // Single requester 2, gap 4: immediate ready, 4 busy cycles, regrant at +5
        a_data[47:32] = 16'hBEEF;
        a_valid = 4'b0100;
        #1;
        chk("t1_ready_first", 32'(a_ready), 32'b0100);
        qa.push_back(ent(2, 16'hBEEF));
        @(posedge clk); #1;
        chk("t1_we", 32'(a_we), 1);
        chk("t1_wdata", 32'(a_wd), 32'hBEEF);
        for (int k = 0; k < 4; k++) begin
            chk("t1_busy_holdoff", 32'(a_busy), 1);
            chk("t1_ready_holdoff", 32'(a_ready), 0);
            @(posedge clk); #1;
        end
        chk("t1_busy_clear", 32'(a_busy), 0);
        chk("t1_ready_again", 32'(a_ready), 32'b0100);
        qa.push_back(ent(2, 16'hBEEF));
        @(posedge clk); #1;
        a_valid = '0;

        // Req 1 withdraws during HOLDOFF, req 3 stays: req 3 wins on return
        repeat (5) @(posedge clk);
        #1;
        a_data[15:0] = 16'h1111;
        a_valid = 4'b0001;
        #1;
        chk("t5_ready_req0", 32'(a_ready), 32'b0001);
        qa.push_back(ent(0, 16'h1111));
        @(posedge clk); #1;
        a_data[31:16] = 16'h2222;
        a_data[63:48] = 16'h3333;
        a_valid = 4'b1010;
        #1;
        chk("t5_ready_in_holdoff", 32'(a_ready), 0);
        @(posedge clk); @(posedge clk); #1;
        a_valid = 4'b1000;
        #1;
        n = 0;
        while (a_ready == '0 && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        chk("t5_ready_req3", 32'(a_ready), 32'b1000);
        qa.push_back(ent(3, 16'h3333));
        @(posedge clk); #1;
        a_valid = '0;

        // All four valid, gap 0: strict 0,1,2,3 order, write every cycle
        b_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        b_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("t2_rr_ready", 32'(b_ready), 32'(4'b0001 << (k % 4)));
            qb.push_back(ent(k % 4, 16'hB000 + 16'(k % 4)));
            @(posedge clk); #1;
            chk("t2_we_every_cycle", 32'(b_we), 1);
        end
        b_valid = '0;

        // Reset during a transfer cycle (B) and during HOLDOFF (A)
        a_data[31:16] = 16'h4444;
        a_valid = 4'b0010;
        b_valid = 4'b0100;
        #1;
        chk("t4_b_ready_req2", 32'(b_ready), 32'b0100);
        chk("t4_a_ready_req1", 32'(a_ready), 32'b0010);
        qb.push_back(ent(2, 16'hB002));
        qa.push_back(ent(1, 16'h4444));
        @(posedge clk); #1;
        a_valid = '0;
        b_valid = 4'b0010;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        b_valid = '0;
        #1;
        chk("t4_we_suppressed", 32'(b_we), 0);
        chk("t4_a_busy_cleared", 32'(a_busy), 0);
        b_valid = 4'b1111;
        #1;
        chk("t4_ptr_back_to_0", 32'(b_ready), 32'b0001);
        qb.push_back(ent(0, 16'hB000));
        @(posedge clk); #1;
        b_valid = '0;

        // Single requester 0 on A: granted every 5 cycles, 20 grants
        a_data[15:0] = 16'h6000;
        a_valid = 4'b0001;
        #1;
        for (int g = 0; g < 20; g++) begin
            n = 0;
            while (a_ready == '0 && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t6_ready_req0", 32'(a_ready), 32'b0001);
            chk("t6_wait_cycles", 32'(n), (g == 0) ? 32'd0 : 32'd4);
            qa.push_back(ent(0, 16'h6000 + 16'(g)));
            @(posedge clk); #1;
            a_data[15:0] = 16'h6000 + 16'(g + 1);
        end
        a_valid = '0;
`ifdef CDC_WRITE_ARBITER_STATS_EN
        a_sel = 2'd0;
        @(posedge clk); #1;
        chk("t6_stat_sat_req0", 32'(a_cnt), 32'd15);
        for (int s = 1; s < 4; s++) begin
            a_sel = 2'(s);
            @(posedge clk); #1;
            chk("t6_stat_other", 32'(a_cnt), 0);
        end
`endif

        // Three requesters, gap 0: pointer wraps 2 -> 0
        c_data = {16'hC002, 16'hC001, 16'hC000};
        c_valid = 3'b111;
        #1;
        for (int k = 0; k < 7; k++) begin
            chk("t3_rr3_ready", 32'(c_ready), 32'(3'b001 << (k % 3)));
            qc.push_back(ent(k % 3, 16'hC000 + 16'(k % 3)));
            @(posedge clk); #1;
        end
        c_valid = '0;

        repeat (8) @(posedge clk);
        #1;
        chk("end_qa_drained", 32'(qa.size()), 0);
        chk("end_qb_drained", 32'(qb.size()), 0);
        chk("end_qc_drained", 32'(qc.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
